// File: rtl/regfile_32x32.sv
// ---------------------------------------------------------------------------
// regfile_32x32
//
// Two-read, one-write MIPS general-purpose register file. Both read ports are
// registered and feed alu_32 input_a / input_b directly. Register $0 is
// hardwired to zero: writes to it are dropped and flagged on err_write_zero.
//
// Optional feature, selected at compile time:
//   REGFILE_BYPASS_EN  when defined, a write presented in the same cycle as a
//                      read of the same (non-zero) address is forwarded to the
//                      read port. When undefined, the read returns the old
//                      stored value and the pipeline resolves the hazard.
//
// Ports:
//   clock           in   1           rising-edge clock
//   reset           in   1           synchronous active-high reset; clears
//                                    every register and all outputs
//   hold            in   1           stall: read outputs keep their values
//   read_addr_a     in   ADDR_WIDTH  port A read address (rs)
//   read_addr_b     in   ADDR_WIDTH  port B read address (rt)
//   write_en        in   1           write strobe
//   write_addr      in   ADDR_WIDTH  write address (rd/rt)
//   write_data      in   DATA_WIDTH  write value
//   read_data_a     out  DATA_WIDTH  registered port A data
//   read_data_b     out  DATA_WIDTH  registered port B data
//   err_write_zero  out  1           one-cycle flag: a write to $0 was seen
//
// Interface contract: there is no valid/ready handshake. Every non-reset
// edge with write_en=1 commits a write (unless it targets $0), and every
// non-reset edge with hold=0 captures a read on both ports; all outputs are
// registered, so nothing propagates combinationally from inputs to outputs.
// ---------------------------------------------------------------------------
module regfile_32x32 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  hold,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b,
  output logic                  err_write_zero
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_read_data_a;
  logic [DATA_WIDTH-1:0] r_read_data_b;
  logic                  r_err_write_zero;

  logic                  w_write_commit;
  logic                  w_write_zero;
  logic [DATA_WIDTH-1:0] w_next_a;
  logic [DATA_WIDTH-1:0] w_next_b;

  // A write to $0 never commits; it only raises the error flag.
  assign w_write_commit = write_en && (write_addr != '0);
  assign w_write_zero   = write_en && (write_addr == '0);

  // Read-side selection for one port: $0 first, then (optionally) the
  // in-flight write, then the stored word as it was before this edge.
  function automatic logic [DATA_WIDTH-1:0] read_word(
    input logic [ADDR_WIDTH-1:0] addr
  );
    logic [DATA_WIDTH-1:0] value;
    value = '0;
    if (addr == '0) begin
      value = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (w_write_commit && (write_addr == addr)) begin
      // w_write_commit excludes $0, so a $0 write is never forwarded.
      value = write_data;
    end
`endif
    else begin
      value = r_mem[addr];
    end
    return value;
  endfunction

  always_comb begin
    w_next_a = '0;
    w_next_b = '0;
    w_next_a = read_word(read_addr_a);
    w_next_b = read_word(read_addr_b);
  end

  // Storage. Reset wins over any write presented in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_write_commit) begin
      r_mem[write_addr] <= write_data;
    end
  end

  // Read registers and error flag. hold freezes only the read registers;
  // writes and the error flag keep moving during a stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_read_data_a    <= '0;
      r_read_data_b    <= '0;
      r_err_write_zero <= 1'b0;
    end else begin
      r_err_write_zero <= w_write_zero;
      if (!hold) begin
        r_read_data_a <= w_next_a;
        r_read_data_b <= w_next_b;
      end
    end
  end

  assign read_data_a    = r_read_data_a;
  assign read_data_b    = r_read_data_b;
  assign err_write_zero = r_err_write_zero;

endmodule

// File: tb/tb_regfile_32x32.sv
// ---------------------------------------------------------------------------
// tb_regfile_32x32
//
// Directed, table-driven bench for regfile_32x32. Each table row holds the
// inputs presented before one rising edge and the outputs expected just after
// it. A hand-written sweep afterwards fills every register and reads them back
// in pairs, and checks the operand pair that drives an alu_32 add overflow.
// ---------------------------------------------------------------------------
module tb_regfile_32x32;

  localparam int DW = 32;
  localparam int AW = 5;

`ifdef REGFILE_BYPASS_EN
  localparam logic [DW-1:0] HAZARD_EXP = 32'h2;
`else
  localparam logic [DW-1:0] HAZARD_EXP = 32'h1;
`endif

  // ---------------- clock / reset ----------------
  logic          clock;
  logic          reset;
  logic          hold;
  logic [AW-1:0] read_addr_a;
  logic [AW-1:0] read_addr_b;
  logic          write_en;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data_a;
  logic [DW-1:0] read_data_b;
  logic          err_write_zero;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  regfile_32x32 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock         (clock),
    .reset         (reset),
    .hold          (hold),
    .read_addr_a   (read_addr_a),
    .read_addr_b   (read_addr_b),
    .write_en      (write_en),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .read_data_a   (read_data_a),
    .read_data_b   (read_data_b),
    .err_write_zero(err_write_zero)
  );

  // ---------------- vector table ----------------
  typedef struct {
    string         name;
    logic          rst;
    logic          hld;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    logic          exp_err;
  } vec_t;

  vec_t tbl[$];

  int n_vec  = 0;
  int n_fail = 0;

  // Scoreboard for the sweep: expected port A/B words in issue order.
  logic [DW-1:0] exp_q[$];

  function automatic vec_t mk(string name, logic rst, logic hld, logic we,
                              logic [AW-1:0] wa, logic [DW-1:0] wd,
                              logic [AW-1:0] ra, logic [AW-1:0] rb,
                              logic [DW-1:0] ea, logic [DW-1:0] eb, logic ee);
    vec_t v;
    v.name = name; v.rst = rst; v.hld = hld; v.we = we; v.wa = wa; v.wd = wd;
    v.ra = ra; v.rb = rb; v.exp_a = ea; v.exp_b = eb; v.exp_err = ee;
    return v;
  endfunction

  function automatic logic [DW-1:0] pattern(int idx);
    logic [DW-1:0] p;
    p = (32'h0101_0101 * idx) ^ 32'hA5A5_0000;
    return p;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic hld, input logic we,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    reset = rst; hold = hld; write_en = we; write_addr = wa; write_data = wd;
    read_addr_a = ra; read_addr_b = rb;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] ea,
                       input logic [DW-1:0] eb, input logic ee);
    n_vec++;
    if (read_data_a !== ea || read_data_b !== eb || err_write_zero !== ee) begin
      n_fail++;
      $display("FAIL %s: got a=%h b=%h err=%b, want a=%h b=%h err=%b",
               name, read_data_a, read_data_b, err_write_zero, ea, eb, ee);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    reset = 1'b1; hold = 1'b0; write_en = 1'b0; write_addr = '0;
    write_data = '0; read_addr_a = '0; read_addr_b = '0;

    //                name          rst hld we  wa     wd             ra     rb     exp_a          exp_b          err
    tbl.push_back(mk("reset0",      1, 0, 0, 5'd0,  32'h0,         5'd0,  5'd0,  32'h0,         32'h0,         0));
    tbl.push_back(mk("preload5",    0, 0, 1, 5'd5,  32'h1234,      5'd0,  5'd0,  32'h0,         32'h0,         0));
    tbl.push_back(mk("read5",       0, 0, 0, 5'd0,  32'h0,         5'd5,  5'd5,  32'h1234,      32'h1234,      0));
    tbl.push_back(mk("rst_wr7",     1, 0, 1, 5'd7,  32'hABCD,      5'd5,  5'd5,  32'h0,         32'h0,         0));
    tbl.push_back(mk("post_rst",    0, 0, 0, 5'd0,  32'h0,         5'd5,  5'd7,  32'h0,         32'h0,         0));
    tbl.push_back(mk("wr3",         0, 0, 1, 5'd3,  32'hDEADBEEF,  5'd0,  5'd0,  32'h0,         32'h0,         0));
    tbl.push_back(mk("rd3_both",    0, 0, 0, 5'd0,  32'h0,         5'd3,  5'd3,  32'hDEADBEEF,  32'hDEADBEEF,  0));
    tbl.push_back(mk("wr_zero",     0, 0, 1, 5'd0,  32'hFFFFFFFF,  5'd3,  5'd0,  32'hDEADBEEF,  32'h0,         1));
    tbl.push_back(mk("err_drop",    0, 0, 0, 5'd0,  32'h0,         5'd0,  5'd0,  32'h0,         32'h0,         0));
    tbl.push_back(mk("wr9_1",       0, 0, 1, 5'd9,  32'h1,         5'd3,  5'd0,  32'hDEADBEEF,  32'h0,         0));
    tbl.push_back(mk("hazard9",     0, 0, 1, 5'd9,  32'h2,         5'd9,  5'd9,  HAZARD_EXP,    HAZARD_EXP,    0));
    tbl.push_back(mk("rd9_after",   0, 0, 0, 5'd0,  32'h0,         5'd9,  5'd0,  32'h2,         32'h0,         0));
    tbl.push_back(mk("wr10_aa",     0, 0, 1, 5'd10, 32'hAA,        5'd0,  5'd0,  32'h0,         32'h0,         0));
    tbl.push_back(mk("rd10",        0, 0, 0, 5'd0,  32'h0,         5'd10, 5'd3,  32'hAA,        32'hDEADBEEF,  0));
    tbl.push_back(mk("hold1_wr4",   0, 1, 1, 5'd4,  32'hBB,        5'd9,  5'd0,  32'hAA,        32'hDEADBEEF,  0));
    tbl.push_back(mk("hold2",       0, 1, 0, 5'd0,  32'h0,         5'd4,  5'd4,  32'hAA,        32'hDEADBEEF,  0));
    tbl.push_back(mk("hold3_wr0",   0, 1, 1, 5'd0,  32'h5,         5'd0,  5'd9,  32'hAA,        32'hDEADBEEF,  1));
    tbl.push_back(mk("unhold_rd4",  0, 0, 0, 5'd0,  32'h0,         5'd4,  5'd10, 32'hBB,        32'hAA,        0));
    tbl.push_back(mk("wr1_max",     0, 0, 1, 5'd1,  32'h7FFFFFFF,  5'd0,  5'd0,  32'h0,         32'h0,         0));
    tbl.push_back(mk("wr2_rd1",     0, 0, 1, 5'd2,  32'h1,         5'd1,  5'd0,  32'h7FFFFFFF,  32'h0,         0));
    tbl.push_back(mk("rd1_rd2",     0, 0, 0, 5'd0,  32'h0,         5'd1,  5'd2,  32'h7FFFFFFF,  32'h1,         0));
    tbl.push_back(mk("no_fwd_zero", 0, 0, 1, 5'd0,  32'h123,       5'd0,  5'd0,  32'h0,         32'h0,         1));
    tbl.push_back(mk("rst_hold_z",  1, 1, 1, 5'd0,  32'h77,        5'd1,  5'd2,  32'h0,         32'h0,         0));
    tbl.push_back(mk("rst_clear3",  0, 0, 0, 5'd0,  32'h0,         5'd3,  5'd4,  32'h0,         32'h0,         0));
    tbl.push_back(mk("rst_clear12", 0, 0, 0, 5'd0,  32'h0,         5'd1,  5'd2,  32'h0,         32'h0,         0));

    @(negedge clock);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].hld, tbl[i].we, tbl[i].wa, tbl[i].wd,
            tbl[i].ra, tbl[i].rb);
      check(tbl[i].name, tbl[i].exp_a, tbl[i].exp_b, tbl[i].exp_err);
    end

    // ALU hookup: the operand pair must sum to the signed-overflow result.
    drive(0, 0, 0, 5'd0, 32'h0, 5'd1, 5'd1);
    drive(0, 0, 1, 5'd1, 32'h7FFFFFFF, 5'd0, 5'd0);
    drive(0, 0, 1, 5'd2, 32'h1, 5'd0, 5'd0);
    drive(0, 0, 0, 5'd0, 32'h0, 5'd1, 5'd2);
    n_vec++;
    if ((read_data_a + read_data_b) !== 32'h80000000) begin
      n_fail++;
      $display("FAIL alu_sum: got %h, want %h", read_data_a + read_data_b,
               32'h80000000);
    end

    // Sweep: fill r1..r31 with distinct patterns, then read pairs (i, 32-i).
    for (int i = 1; i < 32; i++) begin
      drive(0, 0, 1, AW'(i), pattern(i), 5'd0, 5'd0);
    end
    for (int i = 1; i < 32; i++) begin
      exp_q.push_back(pattern(i));
      exp_q.push_back(pattern(32 - i));
    end
    for (int i = 1; i < 32; i++) begin
      logic [DW-1:0] ea;
      logic [DW-1:0] eb;
      drive(0, 0, 0, 5'd0, 32'h0, AW'(i), AW'(32 - i));
      ea = exp_q.pop_front();
      eb = exp_q.pop_front();
      check($sformatf("sweep_r%0d", i), ea, eb, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_32x32.md
# regfile_32x32

Two-read, one-write 32 x 32-bit MIPS general-purpose register file sitting directly upstream of `alu_32`. Its registered read ports drive `alu_32` `input_a` and `input_b`. Register $0 is hardwired to zero. An optional write-to-read bypass lets a value written in cycle N be read back in that same cycle.

## Interface
Parameters:
- `DATA_WIDTH`, 32: register and port data width.
- `ADDR_WIDTH`, 5: register address width; depth is 2**ADDR_WIDTH.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `hold`  in  1  stall; when high, the read outputs keep their current values.
- `read_addr_a`  in  ADDR_WIDTH  port A read address (operand rs).
- `read_addr_b`  in  ADDR_WIDTH  port B read address (operand rt).
- `write_en`  in  1  write strobe.
- `write_addr`  in  ADDR_WIDTH  write address (destination rd/rt).
- `write_data`  in  DATA_WIDTH  write value (ALU `result` or load data).
- `read_data_a`  out  DATA_WIDTH  registered port A data; feeds `alu_32` `input_a`.
- `read_data_b`  out  DATA_WIDTH  registered port B data; feeds `alu_32` `input_b`.
- `err_write_zero`  out  1  one-cycle registered flag: a write to $0 was attempted.

## Operation
- Storage: 2**ADDR_WIDTH words. Word 0 is never written and always reads 0.
- Write path:
  - On a rising edge with `write_en`=1, `write_addr`!=0 and `reset`=0: `mem[write_addr]` <= `write_data`.
  - A write with `write_addr`=0 is discarded, and `err_write_zero` is 1 for exactly the following cycle.
- Read path, on a rising edge with `hold`=0 and `reset`=0, applied to each port P independently:
  - if `read_addr_P`=0, `read_data_P` <= 0;
  - else, with the bypass compiled in, if `write_en`=1 and `write_addr`=`read_addr_P`, `read_data_P` <= `write_data`;
  - otherwise `read_data_P` <= `mem[read_addr_P]` (the pre-edge value).
- `hold`=1: `read_data_a` and `read_data_b` keep their values. Writes still commit, and `err_write_zero` still updates.
- Both ports may use the same address; both then return identical data.
- Outputs depend only on registered state; there is no combinational path from inputs to outputs.

## Timing
- Read latency: 1 cycle. An address presented before edge N appears on `read_data_*` after edge N.
- Write-to-read, same address, no bypass: the new value is visible for a read sampled at edge N+1 or later.
- Reset, while `reset`=1 at an edge:
  - all memory words are cleared to 0;
  - `read_data_a`=0, `read_data_b`=0, `err_write_zero`=0;
  - `reset` overrides `write_en` and `hold`; no write commits in a reset cycle.
- Reset asserted mid-stream: a write presented in the reset cycle is lost. The first valid read is the one sampled at the first edge after `reset` falls.
- `err_write_zero` is never asserted during or in the cycle after a reset cycle, even if a $0 write was presented then.

## Configuration
- `REGFILE_BYPASS_EN` defined: same-cycle write data is forwarded to a matching read port, as in Operation. Writes to $0 are never forwarded.
- `REGFILE_BYPASS_EN` undefined: no forwarding. A read matching the write address in the same cycle returns the old stored value. The hazard is then handled by the pipeline's forwarding or stall logic.

## Test plan
- Reset: preload mem[5]=32'h1234, assert `reset` for one cycle with `write_en`=1 to addr 7 -> after release, a read of addr 5 = 0 and of addr 7 = 0; all outputs 0 during reset.
- Basic write/read: write 32'hDEADBEEF to addr 3; next cycle read A=3, B=3 -> both ports 32'hDEADBEEF one edge later.
- $0 protection: write 32'hFFFFFFFF to addr 0 -> `err_write_zero`=1 for one cycle; a read of addr 0 = 0.
- Same-cycle hazard: mem[9]=32'h1, then write 32'h2 to addr 9 while reading A=9 -> `read_data_a`=32'h2 with `REGFILE_BYPASS_EN`, 32'h1 without it.
- Hold: `read_data_a`=32'hAA, assert `hold` for 3 cycles while changing `read_addr_a` and writing 32'hBB to addr 4 -> `read_data_a` stays 32'hAA; after `hold` drops, a read of addr 4 = 32'hBB.
- ALU hookup: write 32'h7FFFFFFF to r1 and 32'h1 to r2, read A=1, B=2 into `alu_32` with add -> `err_overflow`=1, `result`=32'h80000000.
